// File: rtl/ofmap_requant_pack.sv
// Ofmap output stage: bias add, rounding shift, ReLU, int8 saturation, 4-to-1 byte packing.
// FIFO reads are credit-gated against the output buffer so backpressure never drops a pixel.
//
// state | meaning
// IDLE  | waiting for en, FIFO data and a non-zero frame length
// RUN   | issuing FIFO reads until the frame's pixel count is reached
// DRAIN | all reads issued; waiting for the last word handshake
module ofmap_requant_pack #(
   parameter int IN_WIDTH   = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int PACK       = 4,
   parameter int OBUF_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clear,
   input  logic [31:0]                 bias_i,
   input  logic [4:0]                  shift_i,
   input  logic                        relu_en_i,
   input  logic [15:0]                 frame_len_i,
   output logic                        ofmap_fifo_rd_en_o,
   input  logic                        ofmap_fifo_data_valid_i,
   input  logic [IN_WIDTH-1:0]         ofmap_fifo_data_i,
   output logic [PACK*OUT_WIDTH-1:0]   m_data_o,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic                        m_last_o,
   output logic                        frame_done_o,
   output logic                        busy_o
);
   localparam int SW     = IN_WIDTH + 1;
   localparam int RW     = IN_WIDTH + 2;
   localparam int WW     = PACK * OUT_WIDTH;
   localparam int IDXW   = $clog2(PACK);
   localparam int CREDIT = PACK * OBUF_DEPTH;
   localparam int OCCW   = $clog2(CREDIT + 1);
   localparam int PW     = $clog2(OBUF_DEPTH);
   localparam int CW     = $clog2(OBUF_DEPTH + 1);
   localparam logic signed [RW-1:0] QMAX = RW'(2**(OUT_WIDTH-1) - 1);
   localparam logic signed [RW-1:0] QMIN = -QMAX - 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [15:0]            len_q, len_d;
   logic [15:0]            rd_cnt_q, rd_cnt_d;
   logic [OCCW-1:0]        occ_q, occ_d;
   logic                   rd_v_q, rd_last_q;
   logic                   s1_v_q, s1_last_q;
   logic signed [SW-1:0]   sum_q, sum_d;
   logic                   s2_v_q, s2_last_q;
   logic [OUT_WIDTH-1:0]   res_q, res_d;
   logic [WW-1:0]          pack_q;
   logic [IDXW-1:0]        idx_q;
   logic [WW-1:0]          mem_q [OBUF_DEPTH];
   logic [OBUF_DEPTH-1:0]  mlast_q;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic                   rd_en, rd_last, hs, push;
   logic [OCCW-1:0]        dec, last_rem;
   logic signed [RW-1:0]   sum_x, rnd, r_pre, r_sh, r_cl;
   logic [WW-1:0]          byte_w, word_w;

   assign hs           = m_valid_o & m_ready_i;
   assign m_valid_o    = (cnt_q != '0);
   assign m_data_o     = m_valid_o ? mem_q[rd_ptr_q] : '0;
   assign m_last_o     = m_valid_o & mlast_q[rd_ptr_q];
   assign frame_done_o = hs & m_last_o;
   assign busy_o       = (state_q != IDLE);
   assign ofmap_fifo_rd_en_o = rd_en;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rd_cnt_d = rd_cnt_q;
      rd_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && ofmap_fifo_data_valid_i && (frame_len_i != 16'd0)) begin
               state_d  = RUN;
               len_d    = frame_len_i;
               rd_cnt_d = 16'd0;
            end
         end
         RUN: begin
            rd_en = en & ofmap_fifo_data_valid_i & (occ_q < OCCW'(CREDIT)) & (rd_cnt_q < len_q);
            if (rd_en) rd_cnt_d = rd_cnt_q + 16'd1;
            if (rd_cnt_d == len_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (hs && m_last_o) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d  = IDLE;
         rd_cnt_d = 16'd0;
         rd_en    = 1'b0;
      end
   end

   assign rd_last = rd_en & (rd_cnt_q == len_q - 16'd1);

   // A short final word only returns the credits of the pixels it carries.
   assign last_rem = OCCW'(len_q[IDXW-1:0]);
   assign dec   = !hs ? '0 : ((m_last_o && last_rem != '0) ? last_rem : OCCW'(PACK));
   assign occ_d = occ_q + {{(OCCW-1){1'b0}}, rd_en} - dec;

   assign sum_d = {{(SW-IN_WIDTH){ofmap_fifo_data_i[IN_WIDTH-1]}}, ofmap_fifo_data_i}
                + {{(SW-32){bias_i[31]}}, bias_i};

   always_comb begin
      sum_x = {sum_q[SW-1], sum_q};
      rnd   = (shift_i == 5'd0) ? '0 : (RW'(1) << (shift_i - 5'd1));
      r_pre = sum_x + rnd;
      r_sh  = r_pre >>> shift_i;
      r_cl  = (relu_en_i && r_sh[RW-1]) ? '0 : r_sh;
      if (r_cl > QMAX)      res_d = QMAX[OUT_WIDTH-1:0];
      else if (r_cl < QMIN) res_d = QMIN[OUT_WIDTH-1:0];
      else                  res_d = r_cl[OUT_WIDTH-1:0];
   end

   assign byte_w = WW'(res_q) << (idx_q * OUT_WIDTH);
   assign word_w = pack_q | byte_w;
   assign push   = s2_v_q & ((idx_q == IDXW'(PACK - 1)) | s2_last_q);

   always_comb begin
      cnt_d = cnt_q;
      case ({push, hs})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         occ_q     <= '0;
         rd_v_q    <= 1'b0;
         rd_last_q <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_last_q <= 1'b0;
         sum_q     <= '0;
         s2_v_q    <= 1'b0;
         s2_last_q <= 1'b0;
         res_q     <= '0;
         pack_q    <= '0;
         idx_q     <= '0;
         mlast_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else if (clear) begin
         state_q   <= IDLE;
         rd_cnt_q  <= '0;
         occ_q     <= '0;
         rd_v_q    <= 1'b0;
         rd_last_q <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_last_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_last_q <= 1'b0;
         pack_q    <= '0;
         idx_q     <= '0;
         mlast_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_cnt_q  <= rd_cnt_d;
         occ_q     <= occ_d;
         rd_v_q    <= rd_en;
         rd_last_q <= rd_last;
         s1_v_q    <= rd_v_q;
         s1_last_q <= rd_last_q;
         if (rd_v_q) sum_q <= sum_d;
         s2_v_q    <= s1_v_q;
         s2_last_q <= s1_last_q;
         if (s1_v_q) res_q <= res_d;
         if (s2_v_q) begin
            pack_q <= push ? '0 : word_w;
            idx_q  <= push ? '0 : idx_q + IDXW'(1);
         end
         if (push) begin
            mlast_q[wr_ptr_q] <= s2_last_q;
            wr_ptr_q          <= wr_ptr_q + PW'(1);
         end
         if (hs) rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= word_w;
   end
endmodule

// File: doc/ofmap_requant_pack.md
# ofmap_requant_pack

Output stage placed directly downstream of the convolution top level. It drains 32-bit signed accumulator results from the ofmap FIFO and adds a per-layer bias. It then applies a rounding arithmetic right shift, optional ReLU and int8 saturation, and packs four results into one 32-bit word on a valid/ready stream for the DMA write path. FIFO reads are credit-gated so backpressure never drops data.

## Interface
Parameters:
- IN_WIDTH, 32, accumulator width from the ofmap FIFO
- OUT_WIDTH, 8, quantised result width
- PACK, 4, results per output word
- OBUF_DEPTH, 4, output word buffer depth

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  permits issuing new FIFO reads
- clear  in  1  synchronous flush of all state
- bias_i  in  32  signed bias, held stable for the frame
- shift_i  in  5  right-shift amount 0..31, held stable for the frame
- relu_en_i  in  1  clamp negatives to 0
- frame_len_i  in  16  pixels per frame, latched at frame start
- ofmap_fifo_rd_en_o  out  1  read request to ofmap FIFO
- ofmap_fifo_data_valid_i  in  1  FIFO non-empty
- ofmap_fifo_data_i  in  IN_WIDTH  FIFO read data, valid one cycle after rd_en
- m_data_o  out  PACK*OUT_WIDTH  packed word, pixel 0 in bits [7:0]
- m_valid_o  out  1  word available
- m_ready_i  in  1  consumer accepts word
- m_last_o  out  1  final word of frame, qualified by m_valid_o
- frame_done_o  out  1  one-cycle pulse on last-word handshake
- busy_o  out  1  frame in progress

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on en & ofmap_fifo_data_valid_i & frame_len_i != 0. Latch frame_len_i and zero the read counter. frame_len_i == 0 never leaves IDLE.
- RUN: ofmap_fifo_rd_en_o = en & ofmap_fifo_data_valid_i & (occ < PACK*OBUF_DEPTH) & (rd_cnt < len). rd_cnt increments per read. When rd_cnt reaches len, go to DRAIN.
- occ is the pixel credit counter. It increments on each read. It decrements by PACK on each m_valid_o & m_ready_i. On the last word it decrements by the number of valid pixels in that word. Simultaneous increment and decrement nets correctly.
- DRAIN -> IDLE on the handshake of the m_last_o word. frame_done_o pulses in that cycle.
- Arithmetic:
  - sum = sign-extended data + bias, 33 bits.
  - If shift == 0, r = sum. Otherwise r = (sum + 2^(shift-1)) >>> shift, computed in 34 bits.
  - If relu_en_i and r < 0, r = 0.
  - Saturate r to [-128, 127].
- Packing: results fill bytes 0..3 in arrival order. A full word goes to the output buffer. On the frame's last pixel, the word is emitted immediately with the upper bytes zero and m_last_o set.
- The output buffer is a FIFO of OBUF_DEPTH words. The credit scheme guarantees it never overflows.
- en low stops new reads only. In-flight pixels complete and buffered words still drain.
- clear discards in-flight reads, pack register, buffer and counters, and returns to IDLE. clear has priority over all other events.

## Timing
- Reset and clear values:
  - ofmap_fifo_rd_en_o, m_valid_o, m_last_o, frame_done_o and busy_o are 0.
  - m_data_o is 0.
  - occ and rd_cnt are 0.
- Pipeline:
  - Cycle t: rd_en_o high.
  - t+1: FIFO data registered with the bias add.
  - t+2: round, shift, ReLU and saturate registered.
  - t+3: byte written into the pack register.
- The word completed by a read at cycle t shows m_valid_o at t+4 with an empty buffer. This latency is fixed.
- Throughput: one pixel per cycle while m_ready_i stays high.
- m_data_o and m_last_o hold stable while m_valid_o & !m_ready_i.
- m_valid_o is not retracted without a handshake.
- busy_o is high in RUN and DRAIN.

## Test plan
- bias=0, shift=0, relu off, len=4; data 1, -1, 127, 200 -> one word 0x7F7FFF01, m_last_o=1, frame_done_o pulses, state returns to IDLE.
- bias=-100, shift=2, relu on; data 102, 106, 90, 1000 -> bytes 1 (2/4 rounded), 2 (6/4 rounded), 0 (negative, ReLU), 127 (saturated) -> word 0x7F000201.
- len=6, data 1..6 -> words 0x04030201, then 0x00000605 with m_last_o=1; occ returns to 0.
- len=64 with m_ready_i held low -> reads stop after exactly 16 pixels. After release, all 16 words arrive in order with no loss, and rd_en_o never asserts while occ=16.
- Continuous stream with m_ready_i high, len=32 -> rd_en_o high for 32 consecutive cycles. The first m_valid_o comes 4 cycles after the 4th read.
- clear asserted mid-frame with 2 words buffered -> next cycle m_valid_o=0, busy_o=0, occ=0. A fresh frame then starts cleanly with a correct first word.
